spi_slave_ss_wb: RTL and testbench
==================================

// Module: spi_slave_ss_wb
// PURPOSE
// - SPI responder (slave) with a Wishbone register port. It is the far end of an spi_master_ss link.
// - Oversamples sck/ss_L/mosi on clk; no logic clocked by sck.
// - Shifts a WID-bit word in on mosi and a preloaded word out on miso.
// - Sits in the gateware as a loopback/emulation target and as an external-controller command port.
// PARAMETERS
// - BUS_WID  32  Wishbone data/address width.
// - WID      24  bits per SPI transaction.
// - WID_LEN  5   width of the bit counter; 2**WID_LEN > WID.
// - POLARITY 0   CPOL: idle level of sck.
// - PHASE    0   CPHA: 0 = sample on leading edge, 1 = sample on trailing edge.
// PORTS
// - clk       in   1          system clock; must be >= 8x sck frequency.
// - rst       in   1          asynchronous, active-high reset.
// - sck       in   1          SPI clock from master (async).
// - ss_L      in   1          slave select, active low (async).
// - mosi      in   1          master-out data (async).
// - miso      out  1          slave-out data; MSB first.
// - wb_cyc    in   1          bus cycle.
// - wb_stb    in   1          strobe.
// - wb_we     in   1          write enable.
// - wb_sel    in   BUS_WID/8  byte selects; ignored, word access only.
// - wb_addr   in   BUS_WID    byte address; bits [3:0] decoded.
// - wb_dat_w  in   BUS_WID    write data.
// - wb_ack    out  1          acknowledge.
// - wb_dat_r  out  BUS_WID    read data.
// BEHAVIOUR
// - Reset values:
//   - Outputs: miso=0, wb_ack=0, wb_dat_r=0.
//   - Registers: to_master=0, from_master=0, flags=0, state=IDLE.
// - Synchronisers: 2-FF on sck, ss_L and mosi. Edge detect on synced sck uses a third FF.
//   - Latency: pin edge to internal strobe = 3 clk.
// - Edge mapping: leading = sck leaves POLARITY; trailing = sck returns to POLARITY.
//   - Sample edge = leading if PHASE=0, else trailing. The other edge is the shift edge.
// - State machine:
//   - IDLE -> SHIFT on synced ss_L falling edge:
//     - shadow <= to_master;
//     - bit counter <= 0;
//     - busy <= 1;
//     - if PHASE=0, miso <= shadow MSB in the same cycle.
//   - SHIFT: on each sample edge, shift in mosi (MSB first) and increment the counter.
//     - Shift edge: miso <= next bit.
//     - PHASE=1: the first shift edge presents the MSB.
//   - SHIFT -> DONE when counter reaches WID:
//     - from_master <= shift register;
//     - overrun <= done;
//     - done <= 1.
//   - DONE: ignore further sck edges; miso holds the last bit.
//   - DONE -> IDLE on ss_L rising edge; busy <= 0.
//   - SHIFT -> IDLE on ss_L rising edge before WID bits:
//     - aborted <= 1;
//     - from_master unchanged;
//     - done unchanged.
//   - In IDLE, miso = 0 and sck edges are ignored.
// - Register map (word-aligned):
//   - 0x0 STATUS RW: {overrun[3], aborted[2], done[1], busy[0]}. Write 1 to clear bits 1..3; busy is RO.
//   - 0x4 TO_MASTER RW: word sent in the next transaction. A write during SHIFT affects only later transactions.
//   - 0x8 FROM_MASTER RO: last completed received word, zero-extended.
//   - 0xC CONTROL RW: bit0 enable. While enable=0, ss_L falling is ignored.
//   - Other offsets: read 0, writes dropped.
// - Wishbone handshake:
//   - Cycle N has cyc&stb and !ack -> access performed and wb_ack=1 in cycle N+1.
//   - wb_ack drops in N+2.
//   - No wait states, no error/retry.
// - Simultaneous events: a hardware flag set and a W1C clear of that bit in the same cycle -> set wins.
// - Counter/shift width is exactly WID; TO_MASTER/FROM_MASTER bits above WID read 0.
// - Reset mid-transaction: immediate return to IDLE. Bits already received are lost.
// CONFIGURATION
// - SPI_SLAVE_SS_WB_IRQ_EN defined:
//   - Adds output irq (1 bit, reset 0).
//   - Adds CONTROL bit1 irq_mask.
//   - irq = irq_mask & (done | overrun | aborted), registered; asserts 1 clk after the flag.
// - SPI_SLAVE_SS_WB_IRQ_EN undefined:
//   - No irq port.
//   - CONTROL bit1 reads 0 and ignores writes.
// TESTING
// - Mode 0, WID=24: TO_MASTER=0xA5C3F0; master sends 0x123456 -> miso stream 0xA5C3F0, FROM_MASTER=0x123456, STATUS=0x2.
// - Modes 1/2/3: same words through spi_master_ss with matching POLARITY/PHASE -> identical results in each mode.
// - Two transfers with no clear in between: 0x000001 then 0x000002 -> FROM_MASTER=0x2, STATUS=0xA. Writing 0xE to STATUS -> 0x0.
// - ss_L rises after 10 bits -> STATUS=0x4, FROM_MASTER keeps the previous value. The next full transfer still succeeds.
// - enable=0: full transfer -> STATUS=0x0, miso stays 0. rst pulse mid-SHIFT -> all registers back to reset values.
// - IRQ_EN build, irq_mask=1: transfer completes -> irq=1; W1C of done -> irq=0 two clk later.

Source files
------------

// File: rtl/spi_slave_ss_wb.sv
// SPI responder with a Wishbone register port; sck/ss_L/mosi are oversampled on clk.
// Optional build macro SPI_SLAVE_SS_WB_IRQ_EN adds an irq output and CONTROL bit1 irq_mask.
module spi_slave_ss_wb #(
    parameter int BUS_WID  = 32,
    parameter int WID      = 24,
    parameter int WID_LEN  = 5,
    parameter bit POLARITY = 1'b0,
    parameter bit PHASE    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sck,
    input  logic               ss_L,
    input  logic               mosi,
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
    output logic               irq,
`endif
    output logic               miso,
    input  logic               wb_cyc,
    input  logic               wb_stb,
    input  logic               wb_we,
    input  logic [BUS_WID/8-1:0] wb_sel,
    input  logic [BUS_WID-1:0] wb_addr,
    input  logic [BUS_WID-1:0] wb_dat_w,
    output logic               wb_ack,
    output logic [BUS_WID-1:0] wb_dat_r
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sck_sync_q, sck_sync_d;
    logic [2:0]         ss_sync_q, ss_sync_d;
    logic [1:0]         mosi_sync_q, mosi_sync_d;
    logic [WID_LEN-1:0] cnt_q, cnt_d;
    logic [WID-1:0]     shadow_q, shadow_d;
    logic [WID-1:0]     rx_q, rx_d;
    logic [WID-1:0]     to_master_q, to_master_d;
    logic [WID-1:0]     from_master_q, from_master_d;
    logic               miso_q, miso_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               overrun_q, overrun_d;
    logic               enable_q, enable_d;
    logic               ack_q, ack_d;
    logic [BUS_WID-1:0] dat_r_q, dat_r_d;
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
    logic               irq_mask_q, irq_mask_d;
    logic               irq_q, irq_d;
`endif

    logic sck_rise, sck_fall, sample_edge, shift_edge, ss_fall, ss_rise;
    logic set_done, set_aborted, set_overrun;
    logic access, wr;
    logic [2:0] w1c;
    logic [BUS_WID-1:0] rdata;
    logic busy;

    assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
    assign sample_edge = (PHASE == POLARITY) ? sck_rise : sck_fall;
    assign shift_edge  = (PHASE == POLARITY) ? sck_fall : sck_rise;
    assign ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
    assign busy        = (state_q != IDLE);
    assign access      = wb_cyc & wb_stb & ~ack_q;
    assign wr          = access & wb_we;

    always_comb begin
        case (wb_addr[3:0])
            4'h0:    rdata = BUS_WID'({overrun_q, aborted_q, done_q, busy});
            4'h4:    rdata = BUS_WID'(to_master_q);
            4'h8:    rdata = BUS_WID'(from_master_q);
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
            4'hC:    rdata = BUS_WID'({irq_mask_q, enable_q});
`else
            4'hC:    rdata = BUS_WID'(enable_q);
`endif
            default: rdata = '0;
        endcase
    end

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        sck_sync_d    = {sck_sync_q[1:0], sck};
        ss_sync_d     = {ss_sync_q[1:0], ss_L};
        mosi_sync_d   = {mosi_sync_q[0], mosi};
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        rx_d          = rx_q;
        to_master_d   = to_master_q;
        from_master_d = from_master_q;
        miso_d        = miso_q;
        enable_d      = enable_q;
        set_done      = 1'b0;
        set_aborted   = 1'b0;
        set_overrun   = 1'b0;
        ack_d         = access;
        dat_r_d       = dat_r_q;
        w1c           = 3'b000;
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
        irq_mask_d    = irq_mask_q;
        irq_d         = irq_mask_q & (done_q | overrun_q | aborted_q);
`endif

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall && enable_q) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    // PHASE=0 drives the MSB now; PHASE=1 waits for the first shift edge.
                    shadow_d = PHASE ? to_master_q : (to_master_q << 1);
                    miso_d   = PHASE ? 1'b0 : to_master_q[WID-1];
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d     = IDLE;
                    set_aborted = 1'b1;
                    miso_d      = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_d  = {rx_q[WID-2:0], mosi_sync_q[1]};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == WID_LEN'(WID - 1)) begin
                            state_d       = DONE;
                            from_master_d = rx_d;
                            set_done      = 1'b1;
                            set_overrun   = done_q;
                        end
                    end
                    if (shift_edge) begin
                        miso_d   = shadow_q[WID-1];
                        shadow_d = shadow_q << 1;
                    end
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (access && !wb_we) dat_r_d = rdata;
        if (wr) begin
            case (wb_addr[3:0])
                4'h0: w1c = wb_dat_w[3:1];
                4'h4: to_master_d = wb_dat_w[WID-1:0];
                4'hC: begin
                    enable_d = wb_dat_w[0];
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
                    irq_mask_d = wb_dat_w[1];
`endif
                end
                default: ;
            endcase
        end

        // A hardware set in the same cycle as a W1C clear keeps the flag set.
        done_d    = (done_q & ~w1c[0]) | set_done;
        aborted_d = (aborted_q & ~w1c[1]) | set_aborted;
        overrun_d = (overrun_q & ~w1c[2]) | set_overrun;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sck_sync_q    <= {3{POLARITY}};
            ss_sync_q     <= 3'b111;
            mosi_sync_q   <= 2'b00;
            cnt_q         <= '0;
            shadow_q      <= '0;
            rx_q          <= '0;
            to_master_q   <= '0;
            from_master_q <= '0;
            miso_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            overrun_q     <= 1'b0;
            enable_q      <= 1'b0;
            ack_q         <= 1'b0;
            dat_r_q       <= '0;
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
            irq_mask_q    <= 1'b0;
            irq_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sck_sync_q    <= sck_sync_d;
            ss_sync_q     <= ss_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            rx_q          <= rx_d;
            to_master_q   <= to_master_d;
            from_master_q <= from_master_d;
            miso_q        <= miso_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            overrun_q     <= overrun_d;
            enable_q      <= enable_d;
            ack_q         <= ack_d;
            dat_r_q       <= dat_r_d;
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
            irq_mask_q    <= irq_mask_d;
            irq_q         <= irq_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign wb_ack   = ack_q;
    assign wb_dat_r = dat_r_q;
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
    assign irq      = irq_q;
`endif

endmodule

// File: tb/tb_spi_slave_ss_wb.sv
// Directed bench: one responder per SPI mode (index = {CPOL,CPHA}) on a shared Wishbone bus.
module tb_spi_slave_ss_wb;

    localparam int H = 8;  // sck half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck_v  [4];
    logic        ss_v   [4];
    logic        mosi_v [4];
    logic        miso_v [4];
    logic        ack_v  [4];
    logic [31:0] dat_r_v [4];
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
    logic        irq_v  [4];
`endif
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'hF;
    logic [31:0] wb_addr = '0, wb_dat_w = '0;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_slave_ss_wb #(
            .BUS_WID(32), .WID(24), .WID_LEN(5),
            .POLARITY(m >= 2), .PHASE((m % 2) == 1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .sck(sck_v[m]), .ss_L(ss_v[m]), .mosi(mosi_v[m]),
`ifdef SPI_SLAVE_SS_WB_IRQ_EN
            .irq(irq_v[m]),
`endif
            .miso(miso_v[m]),
            .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
            .wb_addr(wb_addr), .wb_dat_w(wb_dat_w),
            .wb_ack(ack_v[m]), .wb_dat_r(dat_r_v[m])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = addr; wb_dat_w = data;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_read(input int idx, input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = addr;
        @(negedge clk);
        check("wb_ack_high", 32'(ack_v[idx]), 32'd1);
        data = dat_r_v[idx];
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        check("wb_ack_low", 32'(ack_v[idx]), 32'd0);
    endtask

    task automatic rd_check(input int idx, input logic [31:0] addr, input logic [31:0] exp,
                            input string tag);
        logic [31:0] d;
        wb_read(idx, addr, d);
        check(tag, d, exp);
    endtask

    // Master for mode m; leaves ss_L low when release_ss is 0.
    task automatic spi_xfer(input int m, input logic [23:0] tx, input int nbits,
                            input bit release_ss, output logic [23:0] rx);
        logic pol, pha;
        pol = (m >= 2);
        pha = ((m % 2) == 1);
        rx  = '0;
        @(negedge clk);
        ss_v[m] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (!pha) begin
                mosi_v[m] = tx[23-i];
                repeat (H) @(negedge clk);
                sck_v[m] = ~pol;
                rx = {rx[22:0], miso_v[m]};
                repeat (H) @(negedge clk);
                sck_v[m] = pol;
            end else begin
                repeat (H) @(negedge clk);
                sck_v[m] = ~pol;
                mosi_v[m] = tx[23-i];
                repeat (H) @(negedge clk);
                sck_v[m] = pol;
                rx = {rx[22:0], miso_v[m]};
            end
        end
        repeat (H) @(negedge clk);
        if (release_ss) begin
            ss_v[m] = 1'b1;
            repeat (2 * H) @(negedge clk);
        end
    endtask

    initial begin
        logic [23:0] rx;
        for (int m = 0; m < 4; m++) begin
            sck_v[m]  = (m >= 2);
            ss_v[m]   = 1'b1;
            mosi_v[m] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_miso", 32'(miso_v[0]), 32'd0);
        check("rst_ack", 32'(ack_v[0]), 32'd0);
        check("rst_dat_r", dat_r_v[0], 32'h0);
        rd_check(0, 32'h0, 32'h0, "rst_status");
        rd_check(0, 32'h4, 32'h0, "rst_to_master");
        rd_check(0, 32'h8, 32'h0, "rst_from_master");
        rd_check(0, 32'hC, 32'h0, "rst_control");

        // Configure all responders; bits above WID are dropped
        wb_write(32'hC, 32'h1);
        wb_write(32'h4, 32'hFFA5C3F0);
        rd_check(0, 32'h4, 32'h00A5C3F0, "to_master_width");
`ifndef SPI_SLAVE_SS_WB_IRQ_EN
        wb_write(32'hC, 32'h3);
        rd_check(0, 32'hC, 32'h1, "control_bit1_ro");
        wb_write(32'hC, 32'h1);
`endif
        rd_check(0, 32'h2, 32'h0, "unmapped_read");

        // One full transfer in each mode
        for (int m = 0; m < 4; m++) begin
            spi_xfer(m, 24'h123456, 24, 1'b1, rx);
            check($sformatf("m%0d_miso_stream", m), 32'(rx), 32'h00A5C3F0);
            rd_check(m, 32'h8, 32'h00123456, $sformatf("m%0d_from_master", m));
            rd_check(m, 32'h0, 32'h2, $sformatf("m%0d_status", m));
        end

        // Read-only FROM_MASTER ignores writes
        wb_write(32'h8, 32'h00ABCDEF);
        rd_check(0, 32'h8, 32'h00123456, "from_master_ro");

        // Overrun: two transfers without a clear
        wb_write(32'h0, 32'hE);
        rd_check(0, 32'h0, 32'h0, "status_cleared");
        spi_xfer(0, 24'h000001, 24, 1'b1, rx);
        spi_xfer(0, 24'h000002, 24, 1'b1, rx);
        check("second_miso_stream", 32'(rx), 32'h00A5C3F0);
        rd_check(0, 32'h8, 32'h00000002, "overrun_from_master");
        rd_check(0, 32'h0, 32'hA, "overrun_status");
        wb_write(32'h0, 32'hE);
        rd_check(0, 32'h0, 32'h0, "overrun_cleared");

        // Abort after 10 bits, then a good transfer
        spi_xfer(0, 24'hFEDCBA, 10, 1'b1, rx);
        rd_check(0, 32'h0, 32'h4, "abort_status");
        rd_check(0, 32'h8, 32'h00000002, "abort_from_master_kept");
        spi_xfer(0, 24'h654321, 24, 1'b1, rx);
        check("after_abort_miso", 32'(rx), 32'h00A5C3F0);
        rd_check(0, 32'h8, 32'h00654321, "after_abort_from_master");
        rd_check(0, 32'h0, 32'h6, "after_abort_status");

        // Disabled responder ignores select
        wb_write(32'h0, 32'hE);
        wb_write(32'hC, 32'h0);
        spi_xfer(0, 24'h777777, 24, 1'b1, rx);
        check("disabled_miso", 32'(rx), 32'h0);
        rd_check(0, 32'h0, 32'h0, "disabled_status");
        rd_check(0, 32'h8, 32'h00654321, "disabled_from_master");

`ifdef SPI_SLAVE_SS_WB_IRQ_EN
        // irq follows done with mask set, drops after W1C
        wb_write(32'hC, 32'h3);
        check("irq_idle", 32'(irq_v[0]), 32'd0);
        spi_xfer(0, 24'h0F0F0F, 24, 1'b1, rx);
        check("irq_set", 32'(irq_v[0]), 32'd1);
        wb_write(32'h0, 32'h2);
        check("irq_cleared", 32'(irq_v[0]), 32'd0);
`endif

        // Reset in the middle of a shift
        wb_write(32'hC, 32'h1);
        spi_xfer(0, 24'hABCDEF, 8, 1'b0, rx);
        rd_check(0, 32'h0, 32'h1, "busy_mid_shift");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_miso", 32'(miso_v[0]), 32'd0);
        rd_check(0, 32'h0, 32'h0, "midrst_status");
        rd_check(0, 32'h4, 32'h0, "midrst_to_master");
        rd_check(0, 32'h8, 32'h0, "midrst_from_master");
        rd_check(0, 32'hC, 32'h0, "midrst_control");
        ss_v[0] = 1'b1;
        repeat (2 * H) @(negedge clk);
        rd_check(0, 32'h0, 32'h0, "midrst_release_status");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
